// File: rtl/kbd_pkg.sv
// Shared constants, scancode FSM encoding and the Set-2 letter lookup
// for the PS/2 letter decoder.
package kbd_pkg;

   localparam logic [4:0] LETTER_NONE = 5'd0;
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_BREAK    = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXT   = 2'd1,
      ST_BREAK = 2'd2
   } sc_state_t;

   // Set-2 make code to letter index (A=1 .. Z=26); 0 for anything else.
   function automatic logic [4:0] sc_to_letter(input logic [7:0] sc);
      logic [4:0] code;
      code = LETTER_NONE;
      case (sc)
         8'h1C: code = 5'd1;
         8'h32: code = 5'd2;
         8'h21: code = 5'd3;
         8'h23: code = 5'd4;
         8'h24: code = 5'd5;
         8'h2B: code = 5'd6;
         8'h34: code = 5'd7;
         8'h33: code = 5'd8;
         8'h43: code = 5'd9;
         8'h3B: code = 5'd10;
         8'h42: code = 5'd11;
         8'h4B: code = 5'd12;
         8'h3A: code = 5'd13;
         8'h31: code = 5'd14;
         8'h44: code = 5'd15;
         8'h4D: code = 5'd16;
         8'h15: code = 5'd17;
         8'h2D: code = 5'd18;
         8'h1B: code = 5'd19;
         8'h2C: code = 5'd20;
         8'h3C: code = 5'd21;
         8'h2A: code = 5'd22;
         8'h1D: code = 5'd23;
         8'h22: code = 5'd24;
         8'h35: code = 5'd25;
         8'h1A: code = 5'd26;
         default: code = LETTER_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, kbdclk glitch filter, 11-bit frame
// assembly with parity/stop check, and a mid-frame idle timeout.
module ps2_frame_rx
   import kbd_pkg::*;
#(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbdclk,
   input  logic       kbddat,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          kclk_s1_q, kclk_s1_d, kclk_s2_q, kclk_s2_d;
   logic          kdat_s1_q, kdat_s1_d, kdat_s2_q, kdat_s2_d;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          frame_err_q, frame_err_d;
   logic          fall;

   always_comb begin
      kclk_s1_d   = kbdclk;
      kclk_s2_d   = kclk_s1_q;
      kdat_s1_d   = kbddat;
      kdat_s2_d   = kdat_s1_q;
      filt_d      = filt_q;
      filt_cnt_d  = filt_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      to_cnt_d    = to_cnt_q;
      frame_err_d = 1'b0;
      byte_valid  = 1'b0;
      fall        = 1'b0;

      // Filtered level flips on the FILTER_CYCLES-th consecutive differing sample.
      if (kclk_s2_q != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
            filt_d     = kclk_s2_q;
            filt_cnt_d = '0;
            fall       = ~kclk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end else begin
         filt_cnt_d = '0;
      end

      if (fall) begin
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd0) begin
            if (kdat_s2_q) frame_err_d = 1'b1;
            else           bit_cnt_d   = 4'd1;
         end else if (bit_cnt_q <= 4'd8) begin
            shift_d   = {kdat_s2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end else if (bit_cnt_q == 4'd9) begin
            par_d     = kdat_s2_q;
            bit_cnt_d = 4'd10;
         end else begin
            bit_cnt_d = 4'd0;
            if ((^{shift_q, par_q}) && kdat_s2_q) byte_valid  = 1'b1;
            else                                  frame_err_d = 1'b1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = 4'd0;
            to_cnt_d    = '0;
         end else if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + TW'(1);
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kclk_s1_q   <= 1'b1;
         kclk_s2_q   <= 1'b1;
         kdat_s1_q   <= 1'b1;
         kdat_s2_q   <= 1'b1;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         kclk_s1_q   <= kclk_s1_d;
         kclk_s2_q   <= kclk_s2_d;
         kdat_s1_q   <= kdat_s1_d;
         kdat_s2_q   <= kdat_s2_d;
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_byte   = shift_q;
   assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_letter_decoder.sv
// PS/2 Set-2 keyboard to 5-bit letter code decoder: frame receiver plus the
// make/extended/break scancode FSM and the held letter output.
module ps2_letter_decoder
   import kbd_pkg::*;
#(
   parameter int         FILTER_CYCLES  = 8,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [4:0] RELEASE_CODE   = 5'd31,
   parameter logic [4:0] OTHER_CODE     = 5'd27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbdclk,
   input  logic       kbddat,
   output logic [4:0] letter,
   output logic       letter_valid,
   output logic       frame_err
);

   // state    | meaning
   // ST_IDLE  | no prefix pending, next byte is a make code or prefix
   // ST_EXT   | E0 seen, next byte is an extended make or F0
   // ST_BREAK | F0 seen, next byte is the released key

   logic [7:0] rx_byte;
   logic       byte_valid;
   sc_state_t  state_q, state_d;
   logic [4:0] letter_q, letter_d;
   logic       letter_valid_q, letter_valid_d;
   logic [4:0] make_code;

   ps2_frame_rx #(
      .FILTER_CYCLES  (FILTER_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .kbdclk     (kbdclk),
      .kbddat     (kbddat),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always_comb begin
      state_d        = state_q;
      letter_d       = letter_q;
      letter_valid_d = 1'b0;
      make_code      = sc_to_letter(rx_byte);
      if (byte_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (rx_byte == SC_BREAK) begin
                  state_d = ST_BREAK;
               end else begin
                  letter_d       = (make_code == LETTER_NONE) ? OTHER_CODE : make_code;
                  letter_valid_d = 1'b1;
               end
            end
            ST_EXT: begin
               if (rx_byte == SC_BREAK) begin
                  state_d = ST_BREAK;
               end else begin
                  letter_d       = OTHER_CODE;
                  letter_valid_d = 1'b1;
                  state_d        = ST_IDLE;
               end
            end
            ST_BREAK: begin
               letter_d       = RELEASE_CODE;
               letter_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         letter_q       <= LETTER_NONE;
         letter_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         letter_q       <= letter_d;
         letter_valid_q <= letter_valid_d;
      end
   end

   assign letter       = letter_q;
   assign letter_valid = letter_valid_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Self-checking bench for ps2_letter_decoder: directed key sequences followed
// by random frames, compared against a byte-level behavioural keyboard model.
module tb_ps2_letter_decoder;

   localparam int FILT = 8;
   localparam int TOUT = 2000;
   localparam int REL  = 31;
   localparam int OTH  = 27;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kbdclk = 1'b1;
   logic       kbddat = 1'b1;
   logic [4:0] letter;
   logic       letter_valid;
   logic       frame_err;

   ps2_letter_decoder #(
      .FILTER_CYCLES  (FILT),
      .TIMEOUT_CYCLES (TOUT),
      .RELEASE_CODE   (5'd31),
      .OTHER_CODE     (5'd27)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .kbdclk       (kbdclk),
      .kbddat       (kbddat),
      .letter       (letter),
      .letter_valid (letter_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int n_err    = 0;
   int n_both   = 0;
   int n_long   = 0;
   logic prev_v = 1'b0;
   logic prev_e = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (letter_valid) n_valid++;
         if (frame_err) n_err++;
         if (letter_valid && frame_err) n_both++;
         if ((letter_valid && prev_v) || (frame_err && prev_e)) n_long++;
      end
      prev_v = letter_valid;
      prev_e = frame_err;
   end

   // Reference model: keyboard events by byte, letter index looked up by position.
   byte unsigned make_tbl [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   int  exp_letter = 0;
   int  exp_valid  = 0;
   int  exp_err    = 0;
   bit  pend_ext   = 1'b0;
   bit  pend_brk   = 1'b0;

   function automatic int lookup(input byte unsigned b);
      for (int i = 0; i < 26; i++) if (make_tbl[i] == b) return i + 1;
      return 0;
   endfunction

   task automatic model_byte(input byte unsigned b);
      int code;
      if (pend_brk) begin
         code = REL;
      end else if (b == 8'hF0) begin
         pend_brk = 1'b1;
         pend_ext = 1'b0;
         return;
      end else if (b == 8'hE0 && !pend_ext) begin
         pend_ext = 1'b1;
         return;
      end else if (pend_ext) begin
         code = OTH;
      end else begin
         code = lookup(b);
         if (code == 0) code = OTH;
      end
      pend_ext   = 1'b0;
      pend_brk   = 1'b0;
      exp_letter = code;
      exp_valid++;
   endtask

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, " letter"}, int'(letter), exp_letter);
      chk({tag, " valid_cnt"}, n_valid, exp_valid);
      chk({tag, " err_cnt"}, n_err, exp_err);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      kbddat = b;
      wait_cyc(10);
      kbdclk = 1'b0;
      wait_cyc(20);
      kbdclk = 1'b1;
      wait_cyc(10);
   endtask

   // Sends the first nbits of a frame; corrupts parity or stop on request.
   task automatic send_bits(input byte unsigned b, input bit bad_par, input bit bad_stop,
                            input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) drive_bit(f[i]);
      kbddat = 1'b1;
   endtask

   task automatic send_frame(input byte unsigned b, input bit bad);
      send_bits(b, bad, 1'b0, 11);
      wait_cyc(5);
      if (bad) exp_err++;
      else     model_byte(b);
   endtask

   initial begin
      byte unsigned rb;
      bit           rbad;
      int           sel;

      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(2);
      chk("reset letter", int'(letter), 0);
      chk("reset valid", int'(letter_valid), 0);
      chk("reset err", int'(frame_err), 0);

      send_frame(8'h1C, 1'b0);
      chk_all("make A");

      send_frame(8'hF0, 1'b0);
      chk_all("break prefix");
      send_frame(8'h1C, 1'b0);
      chk_all("release A");

      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk_all("ext make");
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk_all("ext release");

      send_frame(8'h15, 1'b1);
      chk_all("bad parity");
      send_frame(8'h15, 1'b0);
      chk_all("make Q");
      send_frame(8'h15, 1'b0);
      chk_all("typematic Q");

      send_bits(8'h3A, 1'b0, 1'b1, 11);
      wait_cyc(5);
      exp_err++;
      chk_all("bad stop");

      send_bits(8'h1A, 1'b0, 1'b0, 5);
      wait_cyc(TOUT + 10);
      exp_err++;
      chk_all("timeout");
      send_frame(8'h1A, 1'b0);
      chk_all("make Z");

      kbdclk = 1'b0;
      wait_cyc(FILT - 2);
      kbdclk = 1'b1;
      wait_cyc(30);
      send_frame(8'h24, 1'b0);
      chk_all("glitch then E");

      send_frame(8'hF0, 1'b0);
      send_bits(8'h2C, 1'b0, 1'b0, 4);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      pend_ext   = 1'b0;
      pend_brk   = 1'b0;
      exp_letter = 0;
      wait_cyc(2);
      chk_all("mid-frame reset");
      send_frame(8'h2C, 1'b0);
      chk_all("make T");

      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 9));
         if (sel <= 1)      rb = 8'hF0;
         else if (sel == 2) rb = 8'hE0;
         else if (sel <= 6) rb = make_tbl[$urandom_range(0, 25)];
         else               rb = 8'($urandom);
         rbad = ($urandom_range(0, 7) == 0);
         send_frame(rb, rbad);
         chk_all($sformatf("rand %0d byte %02h bad %0d", k, rb, rbad));
      end

      chk("valid/err overlap", n_both, 0);
      chk("pulse width", n_long, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_letter_decoder.md
# ps2_letter_decoder

Upstream stage of the typing game: receives raw PS/2 keyboard frames on `kbdclk`/`kbddat` and turns Set-2 scancodes into 5-bit letter codes. Its `letter` bus is the level-held `Letter` value the game controller compares cycle to cycle, and its `letter_valid` strobe marks each new key event. It replaces the ad-hoc keyboard wrapper with a checked, filtered, timeout-protected receiver.

## Interface
- `FILTER_CYCLES`, default 8: consecutive equal synchronized samples before `kbdclk` counts as changed.
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles mid-frame before the partial frame is aborted (1 ms at 100 MHz).
- `RELEASE_CODE`, default 5'd31: code emitted for any key release.
- `OTHER_CODE`, default 5'd27: code emitted for a make of a non-letter key.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset. One clock. Reset is synchronous and active-high.
- `kbdclk`  in  1  PS/2 clock, asynchronous.
- `kbddat`  in  1  PS/2 data, asynchronous.
- `letter`  out  5  last decoded event: 0 none, 1–26 = A–Z, `OTHER_CODE`, `RELEASE_CODE`. Held until the next event.
- `letter_valid`  out  1  one-cycle pulse when `letter` is (re)written.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- `kbdclk` and `kbddat` each pass through a 2-FF synchronizer. `kbdclk` is then filtered: the filtered level changes only after `FILTER_CYCLES` identical samples. A filtered 1→0 transition is a falling edge, and `kbddat` (synchronized) is sampled on that cycle.
- Frame format: 11 bits, in order start(0), d0..d7 (LSB first), odd parity, stop(1). A bit counter runs 0..10.
- Start bit sampled as 1: pulse `frame_err`; the counter stays at 0.
- After bit 10 the frame is checked. Parity must be odd over d0..d7 plus the parity bit, and stop must be 1.
  - Pass: the byte goes to the scancode FSM.
  - Fail: pulse `frame_err`, discard the byte, leave the FSM state unchanged.
- Timeout: with the counter at a nonzero value, `TIMEOUT_CYCLES` cycles with no falling edge → pulse `frame_err`, set the counter to 0.
- Scancode FSM, states IDLE, EXT, BREAK:
  - IDLE: 0xE0 → EXT. 0xF0 → BREAK. Letter make code → emit mapped 1–26. Any other byte → emit `OTHER_CODE`.
  - EXT: 0xF0 → BREAK. Any other byte → emit `OTHER_CODE`, go to IDLE.
  - BREAK: any byte → emit `RELEASE_CODE`, go to IDLE.
  - Prefix bytes (0xE0, 0xF0) never emit.
- Letter map, Set-2 make codes: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
- Typematic repeat (same make code again) emits again: `letter_valid` pulses even though `letter` keeps the same value.

## Timing
- Reset values: `letter`=0, `letter_valid`=0, `frame_err`=0. The FSM goes to IDLE, the bit counter to 0, the filtered clock level to 1, the timeout counter to 0.
- Reset mid-frame discards the partial frame and any pending prefix. No `frame_err` is raised.
- Edge detection latency: 2 sync cycles + `FILTER_CYCLES` cycles after the pin falls.
- `letter` and `letter_valid` update on the clock after the cycle that detects the 11th falling edge. `frame_err` has the same timing for parity or stop failures.
- `letter_valid` and `frame_err` are never asserted together, and each lasts exactly one cycle.
- A timeout and a falling edge in the same cycle: the edge wins and the timeout counter clears.
- The timeout counter is 17 bits wide, saturating, and sized with $clog2(TIMEOUT_CYCLES+1).

## Structure
- Package `kbd_pkg`:
  - localparams `LETTER_NONE`=0, `SC_EXT`=8'hE0, `SC_BREAK`=8'hF0.
  - FSM state encoding.
  - function `sc_to_letter(byte) → 5-bit`, returning 0 for non-letters. The top maps 0 to `OTHER_CODE`.
- Sub-module `ps2_frame_rx`: synchronizers, filter, edge detect, shift register, parity/stop check, timeout. Outputs `byte[7:0]`, `byte_valid`, `frame_err`.
- The top holds the scancode FSM and the output registers.

## Test plan
- Reset, then a good frame 0x1C → `letter`=1 with one `letter_valid` pulse, `frame_err` stays 0.
- Frames 0xF0, 0x1C → no pulse after 0xF0; after 0x1C `letter`=31 and `letter_valid` pulses once.
- Frames 0xE0, 0x75 → `letter`=27. Then 0xE0, 0xF0, 0x75 → `letter`=31.
- Frame 0x15 with the parity bit inverted → `frame_err` pulse, `letter` unchanged. Then a good 0x15 → `letter`=17.
- Send 5 bits, stall `kbdclk` high for `TIMEOUT_CYCLES`+10 → one `frame_err` pulse. Then a good 0x1A → `letter`=26.
- A `kbdclk` low glitch of `FILTER_CYCLES`−2 cycles → no bit consumed. Assert `rst` after 4 bits of 0x2C → `letter`=0. The next full 0x2C → `letter`=20.
